// File: rtl/pciecfg_pkg.sv
// rtl/pciecfg_pkg.sv - shared widths, constants and FSM states for the config management arbiter
package pciecfg_pkg;

    localparam int DW_ADDR_W = 10;
    localparam int DATA_W    = 32;
    localparam int BE_W      = 4;

    localparam logic [DATA_W-1:0] ABORT_RDATA = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2,
        GAP   = 2'd3
    } cfg_state_t;

endpackage

// File: rtl/rr_arb.sv
// rtl/rr_arb.sv - round-robin grant: first asserted request at or after ptr, wrapping
module rr_arb #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    int   slot;
    logic found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        slot    = 0;
        for (int k = 0; k < N; k++) begin
            slot = int'(ptr) + k;
            if (slot >= N) begin
                slot = slot - N;
            end
            if (!found && req[slot]) begin
                found     = 1'b1;
                gnt[slot] = 1'b1;
                gnt_idx   = IW'(slot);
            end
        end
    end

endmodule

// File: rtl/cfg_mgmt_arb.sv
// rtl/cfg_mgmt_arb.sv - arbitrates NREQ requesters onto the PCIe config management port with timeout
module cfg_mgmt_arb
    import pciecfg_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NREQ-1:0]                 req_valid,
    input  logic [NREQ-1:0]                 req_we,
    input  logic [NREQ-1:0][DW_ADDR_W-1:0]  req_dwaddr,
    input  logic [NREQ-1:0][BE_W-1:0]       req_byte_en,
    input  logic [NREQ-1:0][DATA_W-1:0]     req_wdata,
    output logic [NREQ-1:0]                 req_done,
    output logic                            req_err,
    output logic [DATA_W-1:0]               req_rdata,
    output logic                            busy,
    output logic [DW_ADDR_W-1:0]            cfg_mgmt_dwaddr,
    output logic                            cfg_mgmt_rd_en,
    output logic                            cfg_mgmt_wr_en,
    output logic [BE_W-1:0]                 cfg_mgmt_byte_en,
    output logic [DATA_W-1:0]               cfg_mgmt_di,
    input  logic [DATA_W-1:0]               cfg_mgmt_do,
    input  logic                            cfg_mgmt_rd_wr_done
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    cfg_state_t           state_q, state_d;
    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0]      gnt_oh_q, gnt_oh_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DW_ADDR_W-1:0] dwaddr_d;
    logic [BE_W-1:0]      be_d;
    logic [DATA_W-1:0]    di_d, rdata_d;
    logic                 rd_en_d, wr_en_d, err_d;
    logic [NREQ-1:0]      done_d;

    logic [NREQ-1:0]      arb_gnt;
    logic [IW-1:0]        arb_idx;

    rr_arb #(.N(NREQ), .IW(IW)) u_rr_arb (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // The management output registers double as the latched request, so
    // requester inputs are only looked at on the IDLE grant cycle.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gnt_oh_d = gnt_oh_q;
        cnt_d    = cnt_q;
        dwaddr_d = cfg_mgmt_dwaddr;
        be_d     = cfg_mgmt_byte_en;
        di_d     = cfg_mgmt_di;
        rd_en_d  = cfg_mgmt_rd_en;
        wr_en_d  = cfg_mgmt_wr_en;
        err_d    = req_err;
        rdata_d  = req_rdata;
        done_d   = '0;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    state_d  = ISSUE;
                    gnt_oh_d = arb_gnt;
                    rr_ptr_d = (int'(arb_idx) == NREQ - 1) ? '0 : arb_idx + 1'b1;
                    cnt_d    = '0;
                    dwaddr_d = req_dwaddr[arb_idx];
                    di_d     = req_wdata[arb_idx];
                    be_d     = req_we[arb_idx] ? req_byte_en[arb_idx] : '0;
                    rd_en_d  = ~req_we[arb_idx];
                    wr_en_d  = req_we[arb_idx];
                end
            end
            ISSUE: begin
                // An ack on the terminal-count cycle takes priority over the abort.
                if (cfg_mgmt_rd_wr_done) begin
                    state_d = RESP;
                    rd_en_d = 1'b0;
                    wr_en_d = 1'b0;
                    rdata_d = cfg_mgmt_wr_en ? '0 : cfg_mgmt_do;
                    err_d   = 1'b0;
                    done_d  = gnt_oh_q;
                end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    state_d = RESP;
                    rd_en_d = 1'b0;
                    wr_en_d = 1'b0;
                    rdata_d = ABORT_RDATA;
                    err_d   = 1'b1;
                    done_d  = gnt_oh_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP:    state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            rr_ptr_q         <= '0;
            gnt_oh_q         <= '0;
            cnt_q            <= '0;
            cfg_mgmt_dwaddr  <= '0;
            cfg_mgmt_byte_en <= '0;
            cfg_mgmt_di      <= '0;
            cfg_mgmt_rd_en   <= 1'b0;
            cfg_mgmt_wr_en   <= 1'b0;
            req_done         <= '0;
            req_err          <= 1'b0;
            req_rdata        <= '0;
            busy             <= 1'b0;
        end else begin
            state_q          <= state_d;
            rr_ptr_q         <= rr_ptr_d;
            gnt_oh_q         <= gnt_oh_d;
            cnt_q            <= cnt_d;
            cfg_mgmt_dwaddr  <= dwaddr_d;
            cfg_mgmt_byte_en <= be_d;
            cfg_mgmt_di      <= di_d;
            cfg_mgmt_rd_en   <= rd_en_d;
            cfg_mgmt_wr_en   <= wr_en_d;
            req_done         <= done_d;
            req_err          <= err_d;
            req_rdata        <= rdata_d;
            busy             <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_cfg_mgmt_arb.sv
// tb/tb_cfg_mgmt_arb.sv - scoreboard bench for cfg_mgmt_arb with directed and randomized traffic
module tb_cfg_mgmt_arb;
    import pciecfg_pkg::*;

    localparam int NREQ = 2;
    localparam int TMO  = 16;
    localparam int NRND = 12;

    logic                           clk = 1'b0;
    logic                           rst;
    logic [NREQ-1:0]                req_valid, req_we, req_done;
    logic [NREQ-1:0][DW_ADDR_W-1:0] req_dwaddr;
    logic [NREQ-1:0][BE_W-1:0]      req_byte_en;
    logic [NREQ-1:0][DATA_W-1:0]    req_wdata;
    logic                           req_err, busy;
    logic [DATA_W-1:0]              req_rdata;
    logic [DW_ADDR_W-1:0]           cfg_mgmt_dwaddr;
    logic                           cfg_mgmt_rd_en, cfg_mgmt_wr_en;
    logic [BE_W-1:0]                cfg_mgmt_byte_en;
    logic [DATA_W-1:0]              cfg_mgmt_di;
    logic [DATA_W-1:0]              cfg_mgmt_do = '0;
    logic                           cfg_mgmt_rd_wr_done = 1'b0;

    always #5 clk = ~clk;

    cfg_mgmt_arb #(.NREQ(NREQ), .TIMEOUT_CYC(TMO)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .req_valid           (req_valid),
        .req_we              (req_we),
        .req_dwaddr          (req_dwaddr),
        .req_byte_en         (req_byte_en),
        .req_wdata           (req_wdata),
        .req_done            (req_done),
        .req_err             (req_err),
        .req_rdata           (req_rdata),
        .busy                (busy),
        .cfg_mgmt_dwaddr     (cfg_mgmt_dwaddr),
        .cfg_mgmt_rd_en      (cfg_mgmt_rd_en),
        .cfg_mgmt_wr_en      (cfg_mgmt_wr_en),
        .cfg_mgmt_byte_en    (cfg_mgmt_byte_en),
        .cfg_mgmt_di         (cfg_mgmt_di),
        .cfg_mgmt_do         (cfg_mgmt_do),
        .cfg_mgmt_rd_wr_done (cfg_mgmt_rd_wr_done)
    );

    typedef struct { int idx; logic [31:0] rdata; logic err; } exp_t;
    typedef struct { logic we; logic [9:0] a; logic [3:0] be; logic [31:0] d; } txn_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] dev_mem [0:1023];
    logic [31:0] ref_mem [0:1023];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Management-port device model: acks after resp_delay enable cycles.
    int   resp_delay = 1;
    int   cur_delay  = 1;
    int   en_cnt     = 0;
    bit   resp_never = 0;
    bit   resp_rand  = 0;
    logic stray_done = 1'b0;

    always @(negedge clk) begin
        cfg_mgmt_rd_wr_done = stray_done;
        cfg_mgmt_do         = 32'hDEAD_BEEF;
        if (cfg_mgmt_rd_en || cfg_mgmt_wr_en) begin
            if (en_cnt == 0) cur_delay = resp_rand ? int'($urandom_range(1, 5)) : resp_delay;
            en_cnt++;
            if (!resp_never && en_cnt == cur_delay) begin
                cfg_mgmt_rd_wr_done = 1'b1;
                if (cfg_mgmt_wr_en) begin
                    for (int b = 0; b < 4; b++)
                        if (cfg_mgmt_byte_en[b]) dev_mem[cfg_mgmt_dwaddr][8*b +: 8] = cfg_mgmt_di[8*b +: 8];
                end else begin
                    cfg_mgmt_do = dev_mem[cfg_mgmt_dwaddr];
                end
            end
        end else begin
            en_cnt = 0;
        end
    end

    // Monitor: every completion pulse is matched against the scoreboard head.
    int   cyc = 0;
    int   last_done_cyc = -1;
    int   gap_start = 1 << 30;
    logic prev_en = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (req_done != 0) begin
            last_done_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(req_done), 32'h0);
            end else begin
                e = exp_q.pop_front();
                chk("done_grant", 32'(req_done), 32'(1 << e.idx));
                chk("done_rdata", req_rdata, e.rdata);
                chk("done_err", 32'(req_err), 32'(e.err));
            end
        end
        if ((cfg_mgmt_rd_en || cfg_mgmt_wr_en) && !prev_en && last_done_cyc > gap_start)
            chk("gap_cycles", 32'(cyc - last_done_cyc), 32'd3);
        prev_en = cfg_mgmt_rd_en | cfg_mgmt_wr_en;
    end

    task automatic count_issue(input int i, output int nr, output int nw);
        int k = 0;
        nr = 0;
        nw = 0;
        while (!req_done[i] && k < 200) begin
            if (cfg_mgmt_rd_en) nr++;
            if (cfg_mgmt_wr_en) nw++;
            @(negedge clk);
            k++;
        end
        chk("done_seen", 32'(req_done[i]), 32'd1);
    endtask

    task automatic issue(input int i, input logic we, input logic [9:0] a, input logic [3:0] be, input logic [31:0] d);
        req_valid[i]   = 1'b1;
        req_we[i]      = we;
        req_dwaddr[i]  = a;
        req_byte_en[i] = be;
        req_wdata[i]   = d;
    endtask

    txn_t tl [2][NRND];
    int   nr, nw;
    int   jp [2];
    int   budget;

    initial begin
        for (int a = 0; a < 1024; a++) begin
            dev_mem[a] = 32'hA500_0000 | a;
            ref_mem[a] = 32'hA500_0000 | a;
        end
        rst = 1'b1;
        req_valid = '0; req_we = '0; req_dwaddr = '0; req_byte_en = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_rd_en", 32'(cfg_mgmt_rd_en), 32'd0);
        chk("rst_wr_en", 32'(cfg_mgmt_wr_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(req_done), 32'd0);
        chk("rst_err", 32'(req_err), 32'd0);
        chk("rst_rdata", req_rdata, 32'd0);
        chk("rst_dwaddr", 32'(cfg_mgmt_dwaddr), 32'd0);
        chk("rst_byte_en", 32'(cfg_mgmt_byte_en), 32'd0);
        chk("rst_di", cfg_mgmt_di, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Read from requester 0, acked on the third enable cycle.
        dev_mem[4] = 32'h10EE_10EE;
        resp_delay = 3;
        exp_q.push_back('{0, 32'h10EE_10EE, 1'b0});
        issue(0, 1'b0, 10'h004, 4'hF, 32'h1234_5678);
        @(negedge clk);
        chk("rd_latency", 32'(cfg_mgmt_rd_en), 32'd1);
        chk("rd_wr_en", 32'(cfg_mgmt_wr_en), 32'd0);
        chk("rd_dwaddr", 32'(cfg_mgmt_dwaddr), 32'h004);
        chk("rd_byte_en", 32'(cfg_mgmt_byte_en), 32'd0);
        chk("busy_issue", 32'(busy), 32'd1);
        req_dwaddr[0] = 10'h3FF;
        req_we[0] = 1'b1;
        count_issue(0, nr, nw);
        chk("rd_en_cycles", 32'(nr), 32'd3);
        chk("rd_wr_cycles", 32'(nw), 32'd0);
        chk("rd_dwaddr_held", 32'(cfg_mgmt_dwaddr), 32'h004);
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", 32'(req_done), 32'd0);
        repeat (2) @(negedge clk);

        // Write from requester 1.
        resp_delay = 2;
        exp_q.push_back('{1, 32'h0, 1'b0});
        issue(1, 1'b1, 10'h001, 4'b0011, 32'h0000_0006);
        @(negedge clk);
        chk("wr_en", 32'(cfg_mgmt_wr_en), 32'd1);
        chk("wr_rd_en", 32'(cfg_mgmt_rd_en), 32'd0);
        chk("wr_byte_en", 32'(cfg_mgmt_byte_en), 32'h3);
        chk("wr_di", cfg_mgmt_di, 32'h6);
        chk("wr_dwaddr", 32'(cfg_mgmt_dwaddr), 32'h001);
        count_issue(1, nr, nw);
        chk("wr_en_cycles", 32'(nw), 32'd2);
        req_valid[1] = 1'b0;
        repeat (3) @(negedge clk);
        chk("wr_device_data", dev_mem[1], 32'hA500_0006);

        // No ack ever: abort after TMO enable cycles.
        resp_never = 1;
        exp_q.push_back('{0, 32'hFFFF_FFFF, 1'b1});
        issue(0, 1'b0, 10'h008, 4'h0, 32'h0);
        @(negedge clk);
        count_issue(0, nr, nw);
        chk("tmo_en_cycles", 32'(nr), 32'(TMO));
        req_valid[0] = 1'b0;
        resp_never = 0;
        repeat (3) @(negedge clk);

        // Ack on the terminal-count cycle wins; requester drops valid mid-flight.
        dev_mem[9] = 32'hCAFE_F00D;
        resp_delay = TMO;
        exp_q.push_back('{0, 32'hCAFE_F00D, 1'b0});
        issue(0, 1'b0, 10'h009, 4'h0, 32'h0);
        @(negedge clk);
        req_valid[0] = 1'b0;
        count_issue(0, nr, nw);
        chk("term_en_cycles", 32'(nr), 32'(TMO));
        repeat (3) @(negedge clk);

        // Stray ack while idle must be ignored.
        stray_done = 1'b1;
        repeat (3) @(negedge clk);
        stray_done = 1'b0;
        chk("stray_busy", 32'(busy), 32'd0);
        chk("stray_en", 32'(cfg_mgmt_rd_en | cfg_mgmt_wr_en), 32'd0);
        @(negedge clk);

        // Reset during the second ISSUE cycle.
        resp_never = 1;
        issue(0, 1'b0, 10'h005, 4'h0, 32'h0);
        @(negedge clk);
        chk("rst_issue_en", 32'(cfg_mgmt_rd_en), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("rst_mid_rd_en", 32'(cfg_mgmt_rd_en), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_rdata", req_rdata, 32'd0);
        rst = 1'b0;
        resp_never = 0;
        repeat (2) @(negedge clk);
        resp_delay = 1;
        exp_q.push_back('{1, 32'hA500_0006, 1'b0});
        issue(1, 1'b0, 10'h006, 4'h0, 32'h0);
        @(negedge clk);
        count_issue(1, nr, nw);
        chk("post_rst_rd_cycles", 32'(nr), 32'd1);
        req_valid[1] = 1'b0;
        repeat (3) @(negedge clk);

        // Random traffic with both requesters always valid: strict alternation from requester 0.
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < NRND; j++) begin
                tl[i][j].we = 1'($urandom_range(0, 1));
                tl[i][j].a  = 10'(16 + $urandom_range(0, 15));
                tl[i][j].be = 4'($urandom);
                tl[i][j].d  = $urandom;
            end
        for (int k = 0; k < 2 * NRND; k++) begin
            txn_t t;
            t = tl[k % 2][k / 2];
            if (t.we) begin
                exp_q.push_back('{k % 2, 32'h0, 1'b0});
                for (int b = 0; b < 4; b++)
                    if (t.be[b]) ref_mem[t.a][8*b +: 8] = t.d[8*b +: 8];
            end else begin
                exp_q.push_back('{k % 2, ref_mem[t.a], 1'b0});
            end
        end
        resp_rand = 1;
        gap_start = cyc;
        jp[0] = 0;
        jp[1] = 0;
        for (int i = 0; i < 2; i++) issue(i, tl[i][0].we, tl[i][0].a, tl[i][0].be, tl[i][0].d);
        budget = 0;
        while ((jp[0] < NRND || jp[1] < NRND) && budget < 3000) begin
            @(negedge clk);
            budget++;
            for (int i = 0; i < 2; i++)
                if (req_done[i] && jp[i] < NRND) begin
                    jp[i]++;
                    if (jp[i] < NRND) issue(i, tl[i][jp[i]].we, tl[i][jp[i]].a, tl[i][jp[i]].be, tl[i][jp[i]].d);
                    else req_valid[i] = 1'b0;
                end
        end
        chk("rand_complete", 32'(jp[0] + jp[1]), 32'(2 * NRND));
        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cfg_mgmt_arb.md
CFG_MGMT_ARB -- requirements
Module: cfg_mgmt_arb

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of requesters (2..4).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 256, number of ISSUE cycles allowed before a transaction is aborted.
REQ-003 SHALL have port clk  in  1  single clock for all logic.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  in  NREQ  per-requester request, held until its req_done.
REQ-006 SHALL have port req_we  in  NREQ  1 = write, 0 = read.
REQ-007 SHALL have port req_dwaddr  in  NREQ x 10  config DW address.
REQ-008 SHALL have port req_byte_en  in  NREQ x 4  write byte enables.
REQ-009 SHALL have port req_wdata  in  NREQ x 32  write data.
REQ-010 SHALL have port req_done  out  NREQ  one-cycle completion pulse to the granted requester.
REQ-011 SHALL have port req_err  out  1  timeout flag, valid with req_done.
REQ-012 SHALL have port req_rdata  out  32  read data, valid with req_done and held until the next completion.
REQ-013 SHALL have port busy  out  1  state != IDLE.
REQ-014 SHALL have ports cfg_mgmt_dwaddr out 10, cfg_mgmt_rd_en out 1, cfg_mgmt_wr_en out 1, cfg_mgmt_byte_en out 4, cfg_mgmt_di out 32: the PCIe core management port.
REQ-015 SHALL have ports cfg_mgmt_do in 32 and cfg_mgmt_rd_wr_done in 1: management read data and ack.

Function
REQ-016 SHALL use the states IDLE, ISSUE, RESP and GAP; all outputs are registered.
REQ-017 In IDLE with any req_valid, SHALL grant the first valid requester at or after rr_ptr (wrapping modulo NREQ), latch its we/dwaddr/byte_en/wdata, set rr_ptr to grant+1 mod NREQ, and go to ISSUE.
REQ-018 In ISSUE SHALL hold rd_en = ~we and wr_en = we continuously, drive dwaddr/di from the latched values, and drive byte_en = latched value for writes and 4'b0 for reads.
REQ-019 SHALL ignore changes to the granted requester's inputs after the latch.
REQ-020 On cfg_mgmt_rd_wr_done = 1 in ISSUE, SHALL deassert both enables on the next edge, capture cfg_mgmt_do for reads (32'h0 for writes), set req_err = 0, and go to RESP.
REQ-021 SHALL count ISSUE cycles; if no done has arrived after TIMEOUT_CYC cycles, SHALL drop the enables, set req_rdata = 32'hFFFF_FFFF and req_err = 1, and go to RESP.
REQ-022 If done coincides with the terminal count, done SHALL win (req_err = 0).
REQ-023 In RESP SHALL pulse req_done[grant] for exactly one cycle, then go to GAP.
REQ-024 GAP SHALL last one cycle with both enables low, then return to IDLE, giving the requester a cycle to drop req_valid.
REQ-025 If a requester drops req_valid mid-transaction, the transaction SHALL still complete and pulse req_done.
REQ-026 SHALL ignore cfg_mgmt_rd_wr_done outside ISSUE.
REQ-027 Minimum latency SHALL be: req_valid edge -> enable high at +1 cycle; done at cycle N -> req_done at N+1.

Reset
REQ-028 On rst, SHALL set state = IDLE, rr_ptr = 0, timeout counter = 0, all enables/req_done/req_err/busy = 0, and dwaddr/byte_en/di/req_rdata = 0.
REQ-029 Reset during ISSUE SHALL drop the enables on the next edge and SHALL NOT pulse req_done.

Structure
REQ-030 The management address/data widths (10/32/4) and the state enum SHALL be defined in pciecfg_pkg.
REQ-031 The round-robin grant SHALL be implemented in a sub-module rr_arb (inputs: request vector, pointer; outputs: one-hot grant and index).

Verification
REQ-032 Read: req0 dwaddr=10'h004, done 3 cycles after enable with do=32'h10EE_10EE -> rd_en high 3 cycles, req_done[0] one pulse, rdata=32'h10EE_10EE, err=0.
REQ-033 Write: req1 dwaddr=10'h001, byte_en=4'b0011, wdata=32'h6 -> wr_en high, byte_en/di match, rd_en=0, req_done[1] pulses.
REQ-034 Both requesters held valid from reset -> grants alternate 0,1,0,1, with exactly one GAP cycle between transactions.
REQ-035 TIMEOUT_CYC=16, done never asserted -> after 16 ISSUE cycles enables=0, req_done pulses, err=1, rdata=32'hFFFF_FFFF.
REQ-036 rst in the 2nd ISSUE cycle -> enables=0 next cycle, no req_done; a later req1 request is granted first with rr_ptr=0 scan.
REQ-037 Done on the 16th ISSUE cycle with TIMEOUT_CYC=16 -> err=0 and rdata=cfg_mgmt_do.
